// File: rtl/key_pkg.sv
// key_pkg: shared types and helpers for the key debouncer.
//   kstate_t          - per-channel debounce FSM state
//   DB_CYCLES_DEFAULT - 20 ms at 100 MHz
//   db_cnt_w(n)       - stability counter width for an n-cycle window
package key_pkg;

  typedef enum logic [1:0] {
    REL   = 2'd0,  // released, stable = 1
    CHK_P = 2'd1,  // candidate press, counting low samples
    PRS   = 2'd2,  // pressed, stable = 0
    CHK_R = 2'd3   // candidate release, counting high samples
  } kstate_t;

  localparam int DB_CYCLES_DEFAULT = 2_000_000;

  function automatic int db_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel.
//   clk, rst    - system clock, async active-high reset
//   key_in      - raw active-low button, asynchronous
//   flag_clr    - write-one-to-clear strobe for key_flag
//   key_stable  - debounced level (1 = released)
//   key_press   - one-cycle pulse on accepted 1->0
//   key_release - one-cycle pulse on accepted 0->1
//   key_flag    - sticky press flag
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  input  logic flag_clr,
  output logic key_stable,
  output logic key_press,
  output logic key_release,
  output logic key_flag
);

  localparam int             CW       = db_cnt_w(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [1:0]    sync_q, sync_d;
  kstate_t       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          flag_q, flag_d;
  logic          sync;
  logic          cnt_done;

  assign sync     = sync_q[1];
  assign cnt_done = (cnt_q == CNT_LAST);

  // State register plus the flops that ride along with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b11;
      state_q   <= REL;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      flag_q    <= flag_d;
    end
  end

  // Next state and counter. Entering a check state counts the current
  // sample as the first one, so acceptance needs DB_CYCLES samples total.
  always_comb begin
    sync_d  = {sync_q[0], key_in};
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      REL: if (!sync) begin
        state_d = CHK_P;
        cnt_d   = CNT_ONE;
      end
      CHK_P: begin
        if (sync) begin
          state_d = REL;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = PRS;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      PRS: if (sync) begin
        state_d = CHK_R;
        cnt_d   = CNT_ONE;
      end
      CHK_R: begin
        if (!sync) begin
          state_d = PRS;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = REL;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = REL;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs. Pulses are decoded from the accepting transition and
  // registered so they line up with the state change.
  always_comb begin
    key_stable = (state_q == REL) || (state_q == CHK_P);
    press_d    = (state_q == CHK_P) && !sync && cnt_done;
    release_d  = (state_q == CHK_R) &&  sync && cnt_done;
    // set wins over a same-cycle clear
    flag_d     = press_q | (flag_q & ~flag_clr);
  end

  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_flag    = flag_q;

endmodule

// File: rtl/key_debounce.sv
// key_debounce: NUM_KEYS independent debounce channels.
//   clk, rst    - system clock, async active-high reset
//   key_in      - raw active-low buttons, asynchronous
//   flag_clr    - W1C strobes for key_flag
//   key_stable  - debounced levels (1 = released)
//   key_press   - one-cycle press pulses
//   key_release - one-cycle release pulses
//   key_flag    - sticky press flags
module key_debounce
  import key_pkg::*;
#(
  parameter int NUM_KEYS  = 4,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic [NUM_KEYS-1:0] flag_clr,
  output logic [NUM_KEYS-1:0] key_stable,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_flag
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES (DB_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in[i]),
      .flag_clr    (flag_clr[i]),
      .key_stable  (key_stable[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_flag    (key_flag[i])
    );
  end

endmodule
